// File: rtl/cordic_sincos.sv
// Iterative 24-step CORDIC rotation: signed Q8.24 angle in, Q8.24 cosine/sine out.
// One request in flight; the arctangent table lives in the fixangles instance below.
module fixangles (
  input  logic [4:0]  step,
  output logic [31:0] angle
);
  // atan(2^-i) in Q8.24, rounded to nearest
  always_comb begin
    angle = 32'h0000_0000;
    case (step)
      5'd0:  angle = 32'h00C90FDB;
      5'd1:  angle = 32'h0076B19C;
      5'd2:  angle = 32'h003EB6EC;
      5'd3:  angle = 32'h001FD5BB;
      5'd4:  angle = 32'h000FFAAE;
      5'd5:  angle = 32'h0007FF55;
      5'd6:  angle = 32'h0003FFEB;
      5'd7:  angle = 32'h0001FFFD;
      5'd8:  angle = 32'h00010000;
      5'd9:  angle = 32'h00008000;
      5'd10: angle = 32'h00004000;
      5'd11: angle = 32'h00002000;
      5'd12: angle = 32'h00001000;
      5'd13: angle = 32'h00000800;
      5'd14: angle = 32'h00000400;
      5'd15: angle = 32'h00000200;
      5'd16: angle = 32'h00000100;
      5'd17: angle = 32'h00000080;
      5'd18: angle = 32'h00000040;
      5'd19: angle = 32'h00000020;
      5'd20: angle = 32'h00000010;
      5'd21: angle = 32'h00000008;
      5'd22: angle = 32'h00000004;
      5'd23: angle = 32'h00000002;
      default: angle = 32'h0000_0000;
    endcase
  end
endmodule

module cordic_sincos #(
  parameter int          ITER  = 24,
  parameter logic [31:0] KINIT = 32'h009B74ED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] angle_in,
  output logic        busy,
  output logic        valid,
  output logic [31:0] cos_out,
  output logic [31:0] sin_out,
  output logic        range_err
);
  localparam int DATA_W = 32;
  localparam logic signed [DATA_W-1:0] PI   = 32'sh03243F6B;
  localparam logic signed [DATA_W-1:0] NPI  = -PI;
  localparam logic signed [DATA_W-1:0] HPI  = 32'sh01921FB5;
  localparam logic signed [DATA_W-1:0] NHPI = -HPI;
  localparam logic [4:0] LAST = 5'(ITER - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                    state;
  logic signed [DATA_W-1:0]  x, y, z;
  logic [4:0]                step;
  logic                      neg;
  logic [DATA_W-1:0]         atan_step;

  logic signed [DATA_W-1:0]  ain, ld_z, xs, ys, x_n, y_n, z_n;
  logic                      ld_err, ld_neg;

  function automatic logic signed [DATA_W-1:0] cond_neg(
    input logic signed [DATA_W-1:0] v,
    input logic                     n
  );
    return n ? -v : v;
  endfunction

  fixangles u_fixangles (
    .step  (step),
    .angle (atan_step)
  );

  // Load decode: range check and fold into [-pi/2, +pi/2]; the fold is undone by negating both results
  always_comb begin
    ain    = signed'(angle_in);
    ld_err = (ain > PI) || (ain < NPI);
    ld_neg = 1'b0;
    ld_z   = ain;
    if (ain > HPI) begin
      ld_z   = ain - PI;
      ld_neg = 1'b1;
    end else if (ain < NHPI) begin
      ld_z   = ain + PI;
      ld_neg = 1'b1;
    end
  end

  // One micro-rotation; direction follows the sign of the residual angle
  always_comb begin
    xs = x >>> step;
    ys = y >>> step;
    if (!z[DATA_W-1]) begin
      x_n = x - ys;
      y_n = y + xs;
      z_n = z - signed'(atan_step);
    end else begin
      x_n = x + ys;
      y_n = y - xs;
      z_n = z + signed'(atan_step);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      valid     <= 1'b0;
      cos_out   <= '0;
      sin_out   <= '0;
      range_err <= 1'b0;
      step      <= '0;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      neg       <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        // The edge that ends DONE may already accept the next request
        S_IDLE, S_DONE: begin
          busy <= 1'b0;
          step <= '0;
          if (start) begin
            if (ld_err) begin
              state     <= S_DONE;
              valid     <= 1'b1;
              range_err <= 1'b1;
              cos_out   <= '0;
              sin_out   <= '0;
            end else begin
              state     <= S_RUN;
              busy      <= 1'b1;
              range_err <= 1'b0;
              x         <= signed'(KINIT);
              y         <= '0;
              z         <= ld_z;
              neg       <= ld_neg;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          x <= x_n;
          y <= y_n;
          z <= z_n;
          if (step == LAST) begin
            state   <= S_DONE;
            busy    <= 1'b0;
            valid   <= 1'b1;
            step    <= '0;
            cos_out <= cond_neg(x_n, neg);
            sin_out <= cond_neg(y_n, neg);
          end else begin
            step <= step + 5'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          step  <= '0;
        end
      endcase
    end
  end
endmodule
